// File: rtl/fft_out_serializer.sv
// fft_out_serializer: buffers parallel 8-bin FFT frames in a two-slot
// ping-pong store and streams them out one bin per valid/ready beat.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   in_valid          one-cycle strobe, in_re/in_im carry a full frame
//   in_re, in_im      bin k at [k*DW +: DW], signed
//   m_valid, m_ready  output handshake
//   m_re, m_im        current bin value from the read slot
//   m_idx, m_last     current bin index, high on bin 7
//   drop, drop_cnt    discard pulse and saturating discard count
module fft_out_serializer #(
   parameter int DW = 24,
   parameter int CW = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   input  logic [8*DW-1:0]      in_re,
   input  logic [8*DW-1:0]      in_im,
   output logic                 m_valid,
   input  logic                 m_ready,
   output logic signed [DW-1:0] m_re,
   output logic signed [DW-1:0] m_im,
   output logic [2:0]           m_idx,
   output logic                 m_last,
   output logic                 drop,
   output logic [CW-1:0]        drop_cnt
);

   // frame storage, never reset
   logic signed [DW-1:0] slot_re [0:1][0:7];
   logic signed [DW-1:0] slot_im [0:1][0:7];

   logic [1:0] count;
   logic       wp;
   logic       rp;
   logic [2:0] idx;

   logic       beat;
   logic       pop;
   logic       accept;
   logic       discard;
   logic [1:0] count_nxt;

   assign m_valid = (count != 2'd0);
   assign m_last  = m_valid & (idx == 3'd7);
   assign m_idx   = idx;
   assign m_re    = slot_re[rp][idx];
   assign m_im    = slot_im[rp][idx];

   assign beat    = m_valid & m_ready;
   assign pop     = beat & m_last;
   // a frame finishing this edge frees its slot for the arriving one
   assign accept  = in_valid & ((count < 2'd2) | pop);
   assign discard = in_valid & ~accept;

   always_comb begin
      count_nxt = count;
      if (accept & ~pop) begin
         count_nxt = count + 2'd1;
      end else if (pop & ~accept) begin
         count_nxt = count - 2'd1;
      end
   end

   // when full, wp == rp, so a write on pop lands in the freed slot
   always_ff @(posedge clk) begin
      if (accept) begin
         for (int k = 0; k < 8; k++) begin
            slot_re[wp][k] <= in_re[k*DW +: DW];
            slot_im[wp][k] <= in_im[k*DW +: DW];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= 2'd0;
         wp    <= 1'b0;
         rp    <= 1'b0;
         idx   <= 3'd0;
      end else begin
         count <= count_nxt;
         if (accept) begin
            wp <= ~wp;
         end
         if (pop) begin
            idx <= 3'd0;
            rp  <= ~rp;
         end else if (beat) begin
            idx <= idx + 3'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         drop     <= 1'b0;
         drop_cnt <= '0;
      end else begin
         drop <= discard;
         if (discard && (drop_cnt != {CW{1'b1}})) begin
            drop_cnt <= drop_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_fft_out_serializer.sv
// Self-checking bench for fft_out_serializer: constant vector table,
// directed corner sequences and random traffic against a queue model.
module tb_fft_out_serializer;

   localparam int DW = 24;
   localparam int CW = 4;
   localparam int CMAX = (1 << CW) - 1;

   typedef struct packed {
      logic [7:0][DW-1:0] re;
      logic [7:0][DW-1:0] im;
   } frame_t;

   typedef struct {
      logic        r;
      logic        iv;
      logic        rdy;
      logic        ev;
      logic [2:0]  eidx;
      int          ere;
      int          eim;
      logic        elast;
   } vec_t;

   logic                 clk;
   logic                 rst;
   logic                 in_valid;
   logic [8*DW-1:0]      in_re;
   logic [8*DW-1:0]      in_im;
   logic                 m_valid;
   logic                 m_ready;
   logic signed [DW-1:0] m_re;
   logic signed [DW-1:0] m_im;
   logic [2:0]           m_idx;
   logic                 m_last;
   logic                 drop;
   logic [CW-1:0]        drop_cnt;

   fft_out_serializer #(.DW(DW), .CW(CW)) dut (
      .clk(clk),
      .rst(rst),
      .in_valid(in_valid),
      .in_re(in_re),
      .in_im(in_im),
      .m_valid(m_valid),
      .m_ready(m_ready),
      .m_re(m_re),
      .m_im(m_im),
      .m_idx(m_idx),
      .m_last(m_last),
      .drop(drop),
      .drop_cnt(drop_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;

   // reference model: queue of stored frames, output position
   frame_t fq[$];
   int     pos = 0;
   int     dcnt = 0;
   bit     dpulse = 0;

   int ref_re[8] = '{200, 0, -40, 0, -40, 0, -40, 0};
   int ref_im[8] = '{0, 0, 40, 0, 0, 0, -40, 0};

   task automatic chk(input string name, input logic [DW-1:0] act,
                      input logic [DW-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic frame_t rand_frame();
      frame_t f;
      for (int k = 0; k < 8; k++) begin
         f.re[k] = DW'($urandom);
         f.im[k] = DW'($urandom);
      end
      return f;
   endfunction

   task automatic check_model();
      bit v;
      v = (fq.size() != 0);
      chk("m_valid", DW'(m_valid), DW'(v));
      chk("m_idx", DW'(m_idx), DW'(pos));
      chk("m_last", DW'(m_last), DW'(v && pos == 7));
      if (v) begin
         chk("m_re", m_re, fq[0].re[pos]);
         chk("m_im", m_im, fq[0].im[pos]);
      end
      chk("drop", DW'(drop), DW'(dpulse));
      chk("drop_cnt", DW'(drop_cnt), DW'(dcnt));
   endtask

   task automatic drive(input logic r, input logic iv, input logic rdy,
                        input frame_t f);
      rst = r;
      in_valid = iv;
      m_ready = rdy;
      in_re = f.re;
      in_im = f.im;
      @(negedge clk);
      check_model();
   endtask

   task automatic tick();
      bit beat, pop, acc;
      frame_t nf;
      if (rst) begin
         fq.delete();
         pos = 0;
         dcnt = 0;
         dpulse = 0;
      end else begin
         beat = (fq.size() != 0) && m_ready;
         pop = beat && (pos == 7);
         acc = in_valid && ((fq.size() < 2) || pop);
         if (pop) begin
            void'(fq.pop_front());
            pos = 0;
         end else if (beat) begin
            pos++;
         end
         if (acc) begin
            nf.re = in_re;
            nf.im = in_im;
            fq.push_back(nf);
         end
         dpulse = in_valid && !acc;
         if (dpulse && dcnt < CMAX) dcnt++;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic step(input logic r, input logic iv, input logic rdy,
                       input frame_t f);
      drive(r, iv, rdy, f);
      tick();
   endtask

   vec_t   tbl[$];
   frame_t ff, fa, fb, fc, fd, z;

   function automatic vec_t mk(input logic r, input logic iv,
                               input logic rdy, input logic ev,
                               input int ei, input logic el);
      vec_t v;
      v.r = r;
      v.iv = iv;
      v.rdy = rdy;
      v.ev = ev;
      v.eidx = 3'(ei);
      v.ere = ev ? ref_re[ei] : 0;
      v.eim = ev ? ref_im[ei] : 0;
      v.elast = el;
      return v;
   endfunction

   initial begin
      z = '0;
      for (int k = 0; k < 8; k++) begin
         ff.re[k] = DW'(ref_re[k]);
         ff.im[k] = DW'(ref_im[k]);
      end

      // full-rate frame: capture, 8 beats, idle
      tbl.push_back(mk(0, 1, 1, 0, 0, 0));
      for (int k = 0; k < 8; k++)
         tbl.push_back(mk(0, 0, 1, 1, k, k == 7));
      tbl.push_back(mk(0, 0, 1, 0, 0, 0));
      // ready toggling 1,0,1,0: beats on odd cycles, hold on even
      tbl.push_back(mk(0, 1, 0, 0, 0, 0));
      for (int c = 1; c <= 15; c++)
         tbl.push_back(mk(0, 0, c % 2, 1, c / 2, (c / 2) == 7));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0));

      rst = 1'b1;
      in_valid = 1'b0;
      m_ready = 1'b0;
      in_re = '0;
      in_im = '0;
      repeat (2) @(posedge clk);
      #1;

      // reset state
      drive(0, 0, 0, z);
      chk("rst_valid", DW'(m_valid), DW'(0));
      chk("rst_idx", DW'(m_idx), DW'(0));
      chk("rst_cnt", DW'(drop_cnt), DW'(0));
      tick();

      foreach (tbl[i]) begin
         drive(tbl[i].r, tbl[i].iv, tbl[i].rdy, ff);
         chk("tbl_valid", DW'(m_valid), DW'(tbl[i].ev));
         if (tbl[i].ev) begin
            chk("tbl_idx", DW'(m_idx), DW'(tbl[i].eidx));
            chk("tbl_re", m_re, DW'(tbl[i].ere));
            chk("tbl_im", m_im, DW'(tbl[i].eim));
         end
         chk("tbl_last", DW'(m_last), DW'(tbl[i].elast));
         tick();
      end

      // three frames back to back while stalled: C drops
      fa = rand_frame();
      fb = rand_frame();
      fc = rand_frame();
      step(0, 1, 0, fa);
      step(0, 1, 0, fb);
      step(0, 1, 0, fc);
      drive(0, 0, 0, z);
      chk("abc_drop", DW'(drop), DW'(1));
      chk("abc_cnt", DW'(drop_cnt), DW'(1));
      tick();
      repeat (17) step(0, 0, 1, z);
      chk("abc_empty", DW'(m_valid), DW'(0));

      // third frame arrives on A's last beat: accepted into freed slot
      fa = rand_frame();
      fb = rand_frame();
      fc = rand_frame();
      step(0, 1, 0, fa);
      step(0, 1, 0, fb);
      for (int i = 0; i < 8; i++) begin
         drive(0, i == 7, 1, fc);
         if (i == 7) chk("pop_last", DW'(m_last), DW'(1));
         tick();
      end
      drive(0, 0, 1, z);
      chk("pop_nodrop", DW'(drop), DW'(0));
      chk("pop_cnt", DW'(drop_cnt), DW'(1));
      tick();
      repeat (15) step(0, 0, 1, z);
      drive(0, 0, 1, z);
      chk("pop_empty", DW'(m_valid), DW'(0));
      tick();

      // reset at A's 4th beat with B queued
      fa = rand_frame();
      fb = rand_frame();
      fd = rand_frame();
      step(0, 1, 0, fa);
      step(0, 1, 0, fb);
      repeat (3) step(0, 0, 1, z);
      drive(1, 0, 1, z);
      chk("rst_mid_idx", DW'(m_idx), DW'(3));
      tick();
      drive(0, 0, 1, z);
      chk("rst_mid_valid", DW'(m_valid), DW'(0));
      chk("rst_mid_cnt", DW'(drop_cnt), DW'(0));
      tick();
      step(0, 1, 0, fd);
      drive(0, 0, 1, z);
      chk("d_idx", DW'(m_idx), DW'(0));
      chk("d_re", m_re, fd.re[0]);
      chk("d_im", m_im, fd.im[0]);
      tick();
      repeat (8) step(0, 0, 1, z);

      // drop counter saturation
      step(0, 1, 0, rand_frame());
      step(0, 1, 0, rand_frame());
      repeat (CMAX - 1) step(0, 1, 0, rand_frame());
      drive(0, 0, 0, z);
      chk("sat_pre", DW'(drop_cnt), DW'(CMAX - 1));
      tick();
      for (int j = 0; j < 3; j++) begin
         step(0, 1, 0, rand_frame());
         drive(0, 0, 0, z);
         chk("sat_drop", DW'(drop), DW'(1));
         chk("sat_cnt", DW'(drop_cnt), DW'(CMAX));
         tick();
      end
      repeat (17) step(0, 0, 1, z);

      // random traffic
      step(1, 0, 0, z);
      for (int i = 0; i < 1500; i++) begin
         step($urandom_range(0, 299) == 0,
              $urandom_range(0, 5) == 0,
              $urandom_range(0, 3) != 0,
              rand_frame());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fft_out_serializer.md
Name: fft_out_serializer

Overview:
Receives one 8-point complex frame per in_valid pulse from the pipelined 8-point FFT, which presents all bins in parallel and has no backpressure. Buffers up to two frames in a ping-pong store and streams them out one bin per beat, in natural bin order 0..7, over a valid/ready interface. Sits between the FFT core and serial downstream consumers such as a magnitude unit, a FIFO or a DMA. Drops and counts frames that arrive when both slots are occupied.

Parameters:
DW, 24, signed width of each real/imag component
CW, 16, width of the dropped-frame counter

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  one-cycle strobe; in_re/in_im hold a complete frame
in_re  in  8*DW  bin k real part at [k*DW +: DW], signed
in_im  in  8*DW  bin k imag part at [k*DW +: DW], signed
m_valid  out  1  output beat available
m_ready  in  1  consumer accepts beat
m_re  out  DW  current bin real part
m_im  out  DW  current bin imag part
m_idx  out  3  current bin index 0..7
m_last  out  1  high when m_idx==7 and m_valid
drop  out  1  one-cycle pulse when an incoming frame is discarded
drop_cnt  out  CW  saturating count of discarded frames

Behaviour:
- Reset (rst=1 at clk edge): count=0, wp=0, rp=0, m_idx=0, m_valid=0, m_last=0, drop=0, drop_cnt=0. Slot contents are not reset. m_re/m_im are don't-care while m_valid=0.
- Storage: two slots, each holding 8 x (re, im). wp is the write slot and rp the read slot. count is 0..2.
- pop = m_valid & m_ready & m_last. beat = m_valid & m_ready.
- Accept = in_valid & (count<2 | pop).
  - On accept: all 16 components are written into slot wp in one cycle and wp toggles.
  - If in_valid & ~accept: the frame is discarded, drop=1 for one cycle, and drop_cnt increments, saturating at 2^CW-1.
- count update:
  - +1 on accept without pop.
  - -1 on pop without accept.
  - Unchanged on both or neither.
- m_valid = (count!=0), a registered-state function.
  - Latency: a frame captured at edge N gives m_valid=1 in the cycle after edge N, with m_idx=0.
- m_re/m_im = slot[rp] lane m_idx. They are driven from stored registers with no combinational path from in_*.
- On beat: m_idx increments. On pop: m_idx wraps to 0 and rp toggles.
- Without a beat, m_re/m_im/m_idx hold stable while m_valid=1 (AXI-style). m_valid never deasserts without a beat.
- Simultaneous accept and pop with count==2: the new frame overwrites the slot being freed (wp==rp at that edge). Output moves to the other, older slot; no drop.
- Simultaneous accept and beat on the same slot is impossible: writes only target non-read slots or the slot being freed.
- Back-to-back in_valid every cycle with m_ready=1: sustained throughput is 1 frame per 8 cycles. The 3rd and later frames arriving within a single 8-beat window drop.
- Reset asserted mid-frame: the partial frame and the queued frame are abandoned. Output restarts clean, with m_idx=0 on the next accepted frame.
- Data passes through bit-exact with no scaling, rounding or reordering.

Test Plan:
- Reset, then one frame of bins 0..7 = (200,0),(0,0),(-40,40),(0,0),(-40,0),(0,0),(-40,-40),(0,0), with m_ready=1 → 8 consecutive beats in cycles 1..8 after capture, exact values, m_idx 0..7, m_last only on beat 8, then m_valid=0.
- Same frame with m_ready toggling 1,0,1,0 → m_re/m_im/m_idx hold during ready=0 cycles, 8 beats total across 15 cycles, no data repeated or skipped.
- Three frames A,B,C on consecutive cycles with m_ready=0 → A and B stored, drop pulses once on C, drop_cnt=1. Releasing ready outputs A then B only.
- Two frames stored with m_ready=1 and a third frame's in_valid coinciding with A's m_last beat → no drop, output A,B,C in order, count returns to 0 after 24 beats.
- Assert rst at A's beat 4 while B is queued → m_valid=0 the next cycle, count=0, drop_cnt=0. A new frame D afterwards starts at m_idx=0 with D's values.
- Force drop_cnt to 2^CW-2, then discard 3 frames → drop_cnt saturates at 2^CW-1, with a drop pulse on each discard.
